// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - SRAM-like req/addr_ok/data_ok bus bundle
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-master SRAM-like arbiter with in-order owner queue
// Optional feature macro: ARB_RR_EN (round-robin grant instead of data-over-inst priority).
module sram_like_arbiter #(
    parameter int OT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    sram_like_arbiter_if.slave         inst_if,
    sram_like_arbiter_if.slave         data_if,
    sram_like_arbiter_if.master        mem_if,
    output logic                       arb_err_o
);
    localparam int   PTR_W    = $clog2(OT_DEPTH);
    localparam int   CNT_W    = PTR_W + 1;
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic [OT_DEPTH-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                lock_valid_q, lock_valid_d;
    logic                lock_owner_q, lock_owner_d;
    logic                arb_err_q, arb_err_d;
`ifdef ARB_RR_EN
    logic                last_winner_q, last_winner_d;
`endif

    logic grant, mem_req, handshake, pop, head, ot_full, ot_empty;

    assign ot_full   = (count_q == CNT_W'(OT_DEPTH));
    assign ot_empty  = (count_q == '0);
    assign head      = owner_q[rd_ptr_q];

    // A pending (locked) request keeps its owner so forwarded fields never switch mid-request.
    always_comb begin
        grant = OWN_INST;
        if (lock_valid_q) grant = lock_owner_q;
`ifdef ARB_RR_EN
        else if (inst_if.req && data_if.req) grant = ~last_winner_q;
`endif
        else if (data_if.req) grant = OWN_DATA;
    end

    assign mem_req   = (inst_if.req | data_if.req) & ~ot_full & ~reset;
    assign handshake = mem_req & mem_if.addr_ok;
    assign pop       = mem_if.data_ok & ~ot_empty & ~reset;

    always_comb begin
        mem_if.wr    = 1'b0;
        mem_if.size  = '0;
        mem_if.addr  = '0;
        mem_if.wstrb = '0;
        mem_if.wdata = '0;
        if (mem_req) begin
            if (grant == OWN_DATA) begin
                mem_if.wr    = data_if.wr;
                mem_if.size  = data_if.size;
                mem_if.addr  = data_if.addr;
                mem_if.wstrb = data_if.wstrb;
                mem_if.wdata = data_if.wdata;
            end else begin
                mem_if.wr    = inst_if.wr;
                mem_if.size  = inst_if.size;
                mem_if.addr  = inst_if.addr;
                mem_if.wstrb = inst_if.wstrb;
                mem_if.wdata = inst_if.wdata;
            end
        end
    end

    assign mem_if.req      = mem_req;
    assign inst_if.addr_ok = handshake & (grant == OWN_INST);
    assign data_if.addr_ok = handshake & (grant == OWN_DATA);
    assign inst_if.data_ok = pop & (head == OWN_INST);
    assign data_if.data_ok = pop & (head == OWN_DATA);
    assign inst_if.rdata   = mem_if.rdata;
    assign data_if.rdata   = mem_if.rdata;
    assign arb_err_o       = arb_err_q;

    always_comb begin
        owner_d      = owner_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        arb_err_d    = arb_err_q;
`ifdef ARB_RR_EN
        last_winner_d = last_winner_q;
`endif
        if (handshake) begin
            owner_d[wr_ptr_q] = grant;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            lock_valid_d      = 1'b0;
`ifdef ARB_RR_EN
            last_winner_d     = grant;
`endif
        end else if (mem_req) begin
            lock_valid_d = 1'b1;
            lock_owner_d = grant;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (handshake && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !handshake) count_d = count_q - CNT_W'(1);
        // A response with nothing outstanding is dropped and flagged until reset.
        if (mem_if.data_ok && ot_empty) arb_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWN_INST;
            arb_err_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_winner_q <= OWN_DATA;
`endif
        end else begin
            owner_q      <= owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            arb_err_q    <= arb_err_d;
`ifdef ARB_RR_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - randomized scoreboard bench for sram_like_arbiter
module tb_sram_like_arbiter;
    localparam int OT_DEPTH = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        int unsigned cyc;
        logic        mreq;
        mreq_t       m;
        logic        iaok;
        logic        daok;
        logic        idok;
        logic        ddok;
        logic        err;
    } cyc_rec_t;

    typedef struct packed {
        int unsigned cyc;
        logic        owner;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    logic arb_err;

    sram_like_arbiter_if inst_if ();
    sram_like_arbiter_if data_if ();
    sram_like_arbiter_if mem_if ();

    sram_like_arbiter #(.OT_DEPTH(OT_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_if   (inst_if),
        .data_if   (data_if),
        .mem_if    (mem_if),
        .arb_err_o (arb_err)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    cyc_rec_t cyc_q[$];
    resp_t    resp_q[$];

    // Reference model: owners of accepted requests, pending (locked) owner, last winner, error flag.
    bit    m_ot[$];
    int    m_lock = -1;
    bit    m_last = 1'b1;
    bit    m_err  = 1'b0;
    bit    i_pend = 1'b0;
    bit    d_pend = 1'b0;
    mreq_t i_r = '0;
    mreq_t d_r = '0;
    int    p_inst, p_data, p_aok, p_dok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic mreq_t rand_req();
        mreq_t r;
        r.wr    = 1'($urandom_range(1));
        r.size  = 2'($urandom_range(2));
        r.addr  = $urandom;
        r.wstrb = 4'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic step(input bit rst, input bit inj);
        cyc_rec_t e;
        resp_t    r;
        bit       gnt, mreq, aok, dok, pop;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            i_pend = 1'b0;
            d_pend = 1'b0;
        end else begin
            if (!i_pend && $urandom_range(99) < p_inst) begin i_pend = 1'b1; i_r = rand_req(); end
            if (!d_pend && $urandom_range(99) < p_data) begin d_pend = 1'b1; d_r = rand_req(); end
        end
        mreq = !rst && (i_pend || d_pend) && (m_ot.size() < OT_DEPTH);
        if (m_lock >= 0)          gnt = (m_lock == 1);
        else if (i_pend && d_pend) gnt = RR ? !m_last : 1'b1;
        else                       gnt = d_pend;
        aok = ($urandom_range(99) < p_aok);
        pop = !rst && (m_ot.size() > 0) && ($urandom_range(99) < p_dok);
        dok = pop || (inj && m_ot.size() == 0);

        reset           = rst;
        inst_if.req     = i_pend;
        inst_if.wr      = i_r.wr;
        inst_if.size    = i_r.size;
        inst_if.addr    = i_r.addr;
        inst_if.wstrb   = i_r.wstrb;
        inst_if.wdata   = i_r.wdata;
        data_if.req     = d_pend;
        data_if.wr      = d_r.wr;
        data_if.size    = d_r.size;
        data_if.addr    = d_r.addr;
        data_if.wstrb   = d_r.wstrb;
        data_if.wdata   = d_r.wdata;
        mem_if.addr_ok  = aok;
        mem_if.data_ok  = dok;
        mem_if.rdata    = $urandom;

        e.cyc  = cyc;
        e.mreq = mreq;
        e.m    = mreq ? (gnt ? d_r : i_r) : '0;
        e.iaok = mreq && aok && !gnt;
        e.daok = mreq && aok && gnt;
        e.idok = pop && (m_ot[0] == 1'b0);
        e.ddok = pop && (m_ot[0] == 1'b1);
        e.err  = m_err;
        cyc_q.push_back(e);

        if (pop) begin
            r.cyc   = cyc;
            r.owner = m_ot.pop_front();
            r.rdata = mem_if.rdata;
            resp_q.push_back(r);
        end else if (dok && !rst) begin
            m_err = 1'b1;
        end
        if (mreq && aok) begin
            m_ot.push_back(gnt);
            m_last = gnt;
            m_lock = -1;
            if (gnt) d_pend = 1'b0;
            else     i_pend = 1'b0;
        end else if (mreq) begin
            m_lock = gnt ? 1 : 0;
        end
        if (rst) begin
            m_ot.delete();
            m_lock = -1;
            m_last = 1'b1;
            m_err  = 1'b0;
        end
    endtask

    task automatic set_mix(input int pi, input int pd, input int pa, input int pk);
        p_inst = pi; p_data = pd; p_aok = pa; p_dok = pk;
    endtask

    // Monitor: per-cycle outputs against the cycle record, responses against the response queue.
    initial begin
        cyc_rec_t e;
        resp_t    r;
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                chk("mem_req",      32'(mem_if.req),      32'(e.mreq));
                chk("mem_wr",       32'(mem_if.wr),       32'(e.m.wr));
                chk("mem_size",     32'(mem_if.size),     32'(e.m.size));
                chk("mem_addr",     mem_if.addr,          e.m.addr);
                chk("mem_wstrb",    32'(mem_if.wstrb),    32'(e.m.wstrb));
                chk("mem_wdata",    mem_if.wdata,         e.m.wdata);
                chk("inst_addr_ok", 32'(inst_if.addr_ok), 32'(e.iaok));
                chk("data_addr_ok", 32'(data_if.addr_ok), 32'(e.daok));
                chk("inst_data_ok", 32'(inst_if.data_ok), 32'(e.idok));
                chk("data_data_ok", 32'(data_if.data_ok), 32'(e.ddok));
                chk("arb_err",      32'(arb_err),         32'(e.err));
            end
            if (inst_if.data_ok || data_if.data_ok) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", 32'({inst_if.data_ok, data_if.data_ok}), 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_cycle", cyc, r.cyc);
                    chk("resp_owner", 32'(data_if.data_ok), 32'(r.owner));
                    chk("resp_rdata", r.owner ? data_if.rdata : inst_if.rdata, r.rdata);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = '0; inst_if.addr = '0;
        inst_if.wstrb = '0; inst_if.wdata = '0;
        data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = '0; data_if.addr = '0;
        data_if.wstrb = '0; data_if.wdata = '0;
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = '0;
        set_mix(0, 0, 100, 0);

        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: set_mix(60, 60, 70, 40);
                1: set_mix(100, 100, 100, 0);
                2: set_mix(80, 80, 30, 60);
                3: set_mix(100, 100, 100, 100);
                4: set_mix(50, 90, 50, 50);
                default: set_mix(90, 20, 80, 30);
            endcase
            repeat (300) step(1'b0, 1'b0);
            if (ph == 2) begin
                step(1'b1, 1'b0);
                step(1'b0, 1'b1);
                step(1'b0, 1'b0);
                step(1'b1, 1'b0);
            end
        end

        set_mix(0, 0, 100, 100);
        repeat (30) step(1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("cyc_q_drained",  32'(cyc_q.size()),  32'd0);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
